// File: rtl/axis_cobs_decode.sv
// axis_cobs_decode
// COBS decoder on AXI4-Stream bytes. Encoded frames are delimited by 0x00 or
// by s_axis_tlast. Decoded frames leave as packets with m_axis_tlast on the
// last byte and m_axis_tuser=1 on that byte if the frame was malformed.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   s_axis_tdata/tvalid/tready      encoded byte input
//   s_axis_tlast                    frame end (as if a 0x00 followed)
//   s_axis_tuser                    upstream error, marks frame bad
//   m_axis_tdata/tvalid/tready      decoded byte output
//   m_axis_tlast/tuser              end of frame / frame bad
module axis_cobs_decode (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tuser,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser
);

  typedef enum logic [1:0] {IDLE, SEGMENT, NEXT_SEG} state_t;

  state_t     r_state, w_nstate;
  logic [7:0] r_cnt, w_ncnt;
  logic       r_code_ff, w_ncode;
  logic       r_err;
  logic [7:0] r_temp;
  logic       r_temp_vld;
  // A data byte carrying tlast needs two pushes (old temp, then itself);
  // the second one is parked in temp and flushed on the next free slot.
  logic       r_flush, r_flush_err;
  logic [7:0] r_m_tdata;
  logic       r_m_tvalid, r_m_tlast, r_m_tuser;

  logic       w_out_free, w_acc, w_temp_vld;
  logic       w_emit, w_end, w_bad, w_load;
  logic [7:0] w_edata;

  assign w_out_free    = !r_m_tvalid || m_axis_tready;
  assign s_axis_tready = rst_n && w_out_free;
  assign w_acc         = s_axis_tvalid && s_axis_tready;
  // While a flush is pending, temp belongs to the finished frame.
  assign w_temp_vld    = r_temp_vld && !r_flush;

  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;
  assign m_axis_tuser  = r_m_tuser;

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = r_cnt;
    w_ncode  = r_code_ff;
    w_emit   = 1'b0;
    w_edata  = 8'h00;
    w_end    = 1'b0;
    w_bad    = r_err || s_axis_tuser;
    w_load   = 1'b0;
    case (r_state)
      IDLE: begin
        if (s_axis_tdata == 8'h00) w_end = 1'b1;
        else                       w_load = 1'b1;
      end
      SEGMENT: begin
        if (s_axis_tdata == 8'h00) begin
          w_end = 1'b1;
          w_bad = 1'b1;
        end else begin
          w_emit  = 1'b1;
          w_edata = s_axis_tdata;
          w_ncnt  = r_cnt - 8'd1;
          if (r_cnt == 8'd1) w_nstate = NEXT_SEG;
        end
      end
      NEXT_SEG: begin
        if (s_axis_tdata == 8'h00) begin
          w_end = 1'b1;
        end else begin
          // a 255 code carries no implicit zero after its block
          w_emit = !r_code_ff;
          w_load = 1'b1;
        end
      end
      default: w_nstate = IDLE;
    endcase
    if (w_load) begin
      w_ncnt   = s_axis_tdata - 8'd1;
      w_ncode  = (s_axis_tdata == 8'hFF);
      w_nstate = (s_axis_tdata == 8'h01) ? NEXT_SEG : SEGMENT;
    end
    if (s_axis_tlast && !w_end) begin
      w_end = 1'b1;
      if (w_nstate == SEGMENT) w_bad = 1'b1;
    end
    if (w_end) begin
      w_nstate = IDLE;
      w_ncnt   = 8'd0;
      w_ncode  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= 8'd0;
      r_code_ff <= 1'b0;
      r_err     <= 1'b0;
    end else if (w_acc) begin
      r_state   <= w_nstate;
      r_cnt     <= w_ncnt;
      r_code_ff <= w_ncode;
      r_err     <= w_end ? 1'b0 : w_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_temp      <= 8'h00;
      r_temp_vld  <= 1'b0;
      r_flush     <= 1'b0;
      r_flush_err <= 1'b0;
      r_m_tdata   <= 8'h00;
      r_m_tvalid  <= 1'b0;
      r_m_tlast   <= 1'b0;
      r_m_tuser   <= 1'b0;
    end else begin
      if (m_axis_tready) r_m_tvalid <= 1'b0;
      if (r_flush && w_out_free) begin
        r_m_tdata  <= r_temp;
        r_m_tlast  <= 1'b1;
        r_m_tuser  <= r_flush_err;
        r_m_tvalid <= 1'b1;
        r_temp_vld <= 1'b0;
        r_flush    <= 1'b0;
      end
      // An input accepted during a flush is always a frame's first byte,
      // which never emits, so the two updates never collide.
      if (w_acc) begin
        if (w_emit && !w_end) begin
          if (w_temp_vld) begin
            r_m_tdata  <= r_temp;
            r_m_tlast  <= 1'b0;
            r_m_tuser  <= 1'b0;
            r_m_tvalid <= 1'b1;
          end
          r_temp     <= w_edata;
          r_temp_vld <= 1'b1;
        end else if (!w_emit && w_end) begin
          if (w_temp_vld) begin
            r_m_tdata  <= r_temp;
            r_m_tlast  <= 1'b1;
            r_m_tuser  <= w_bad;
            r_m_tvalid <= 1'b1;
            r_temp_vld <= 1'b0;
          end
        end else if (w_emit && w_end) begin
          if (w_temp_vld) begin
            r_m_tdata   <= r_temp;
            r_m_tlast   <= 1'b0;
            r_m_tuser   <= 1'b0;
            r_m_tvalid  <= 1'b1;
            r_temp      <= w_edata;
            r_temp_vld  <= 1'b1;
            r_flush     <= 1'b1;
            r_flush_err <= w_bad;
          end else begin
            r_m_tdata  <= w_edata;
            r_m_tlast  <= 1'b1;
            r_m_tuser  <= w_bad;
            r_m_tvalid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_cobs_decode.sv
// Directed bench for axis_cobs_decode: stimulus pushes expected bytes into a
// queue, an independent monitor pops and compares on every output handshake.
module tb_axis_cobs_decode;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_tdata = 8'h00;
  logic       s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
  logic       s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid, m_tlast, m_tuser;
  logic       m_tready = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;
  logic [9:0] exp_q[$];      // {tlast, tuser, tdata}
  bit rnd_rdy = 0;
  bit rdy_fix = 1;
  bit gaps    = 0;

  axis_cobs_decode dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    m_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_fix;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: pops on every handshake, checks stability while stalled
  logic       prev_stall = 1'b0;
  logic [9:0] prev_out;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", {31'd0, m_tvalid}, 32'd1);
        check("stall_hold", {22'd0, m_tlast, m_tuser, m_tdata}, {22'd0, prev_out});
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_out: got %0h expected none", {m_tlast, m_tuser, m_tdata});
        end else begin
          check("out_byte", {22'd0, m_tlast, m_tuser, m_tdata}, {22'd0, exp_q.pop_front()});
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_out   = {m_tlast, m_tuser, m_tdata};
    end
  end

  task automatic expb(input logic [7:0] d, input logic l = 1'b0, input logic u = 1'b0);
    exp_q.push_back({l, u, d});
  endtask

  // entered and left at posedge+1
  task automatic send(input logic [7:0] d, input logic l = 1'b0, input logic u = 1'b0);
    int t;
    bit done;
    if (gaps && $urandom_range(0, 1) == 1) begin
      s_tvalid = 1'b0;
      repeat ($urandom_range(1, 2)) @(posedge clk);
      #1;
    end
    s_tdata = d; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
    t = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      if (s_tready) done = 1;
      @(posedge clk); #1;
      t++;
      if (!done && t > 500) begin
        n_cmp++; n_bad++;
        $display("FAIL send_timeout: got no ready expected ready");
        done = 1;
      end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_empty", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic clean_frame();
    expb(8'h11); expb(8'h22); expb(8'h00); expb(8'h33, 1);
    send(8'h03); send(8'h11); send(8'h22); send(8'h02); send(8'h33); send(8'h00);
  endtask

  task automatic tlast_frame();
    expb(8'hAA); expb(8'hBB); expb(8'hCC); expb(8'hDD, 1);
    send(8'h05); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD, 1);
  endtask

  initial begin
    s_tvalid = 1'b1;  // tready must still be 0 in reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", {31'd0, m_tvalid}, 0);
    check("rst_tdata", {24'd0, m_tdata}, 0);
    check("rst_tlast", {31'd0, m_tlast}, 0);
    check("rst_tuser", {31'd0, m_tuser}, 0);
    check("rst_tready", {31'd0, s_tready}, 0);
    s_tvalid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    clean_frame();
    drain();

    expb(8'h00, 1);
    send(8'h01); send(8'h01); send(8'h00);
    send(8'h01); send(8'h00);                       // no output
    tlast_frame();
    drain();

    for (int i = 1; i <= 254; i++) expb(8'(i));
    expb(8'h55, 1);
    send(8'hFF);
    for (int i = 1; i <= 254; i++) send(8'(i));
    send(8'h02); send(8'h55); send(8'h00);
    drain();

    expb(8'h11); expb(8'h22, 1, 1);
    send(8'h04); send(8'h11); send(8'h22); send(8'h00);
    expb(8'h77, 1, 1);
    send(8'h02); send(8'h77, 0, 1); send(8'h00);
    drain();

    rnd_rdy = 1; gaps = 1;
    clean_frame();
    tlast_frame();
    clean_frame();
    tlast_frame();
    drain();
    rnd_rdy = 0; gaps = 0;

    rdy_fix = 0; m_tready = 1'b0;
    send(8'h04); send(8'h11); send(8'h22);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_tvalid", {31'd0, m_tvalid}, 0);
    check("mid_rst_tdata", {24'd0, m_tdata}, 0);
    check("mid_rst_tlast", {31'd0, m_tlast}, 0);
    check("mid_rst_tready", {31'd0, s_tready}, 0);
    rst_n = 1'b1;
    rdy_fix = 1; m_tready = 1'b1;
    expb(8'h99, 1);
    send(8'h02); send(8'h99); send(8'h00);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
